// File: rtl/dna_port_ctrl.sv
// Sequencer for the DNA_PORT primitive: drives the divided DNA clock and READ/SHIFT strobes,
// captures the device DNA MSB-first and holds the last good value across re-reads.
module dna_port_ctrl #(
    parameter int DW         = 57,
    parameter int CLK_DIV    = 4,
    parameter int AUTO_START = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          dna_dout_i,
    output logic          dna_clk_o,
    output logic          dna_read_o,
    output logic          dna_shift_o,
    output logic [DW-1:0] dna_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DW);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_cnt, div_cnt_nx;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [DW-1:0]    sr, sr_nx, dna_nx, sr_shifted;
    logic             clk_nx, read_nx, shift_nx, valid_nx, done_nx;
    logic             auto_pend, auto_nx;
    logic             tick;

    assign tick       = (div_cnt == DIV_LAST);
    assign sr_shifted = {sr[DW-2:0], dna_dout_i};
    assign busy_o     = (state == LOAD) || (state == SHIFT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            dna_o       <= '0;
            dna_clk_o   <= 1'b0;
            dna_read_o  <= 1'b0;
            dna_shift_o <= 1'b0;
            valid_o     <= 1'b0;
            done_o      <= 1'b0;
            auto_pend   <= (AUTO_START != 0);
        end else begin
            state       <= state_nx;
            div_cnt     <= div_cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            sr          <= sr_nx;
            dna_o       <= dna_nx;
            dna_clk_o   <= clk_nx;
            dna_read_o  <= read_nx;
            dna_shift_o <= shift_nx;
            valid_o     <= valid_nx;
            done_o      <= done_nx;
            auto_pend   <= auto_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        div_cnt_nx = div_cnt;
        bit_cnt_nx = bit_cnt;
        sr_nx      = sr;
        dna_nx     = dna_o;
        clk_nx     = dna_clk_o;
        read_nx    = dna_read_o;
        shift_nx   = dna_shift_o;
        valid_nx   = valid_o;
        done_nx    = 1'b0;
        auto_nx    = auto_pend;

        case (state)
            IDLE, DONE: begin
                clk_nx   = 1'b0;
                read_nx  = 1'b0;
                shift_nx = 1'b0;
                if (start_i || auto_pend) begin
                    state_nx   = LOAD;
                    div_cnt_nx = '0;
                    bit_cnt_nx = '0;
                    sr_nx      = '0;
                    read_nx    = 1'b1;
                    auto_nx    = 1'b0;
                end
            end
            LOAD: begin
                div_cnt_nx = tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    if (!dna_clk_o) begin
                        clk_nx = 1'b1;
                    end else begin
                        // Strobes swap on the falling edge so they are stable around the next rise
                        clk_nx   = 1'b0;
                        read_nx  = 1'b0;
                        shift_nx = 1'b1;
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                div_cnt_nx = tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    if (!dna_clk_o) begin
                        sr_nx = sr_shifted;
                        if (bit_cnt == BIT_LAST) begin
                            // Last bit is already on DOUT: finish without another DNA clock edge
                            state_nx = DONE;
                            shift_nx = 1'b0;
                            dna_nx   = sr_shifted;
                            valid_nx = 1'b1;
                            done_nx  = 1'b1;
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                            clk_nx     = 1'b1;
                        end
                    end else begin
                        clk_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
